// File: rtl/sram_access_scheduler.sv
// Sequences every access to the single async SRAM and arbitrates between the AM and PI requesters.
// AM has priority; PI is forced through after PI_STARVE_LIMIT consecutive AM grants while it waits.
module sram_access_scheduler #(
  parameter int unsigned ADDR_W          = 17,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WAIT_CYCLES     = 2,
  parameter int unsigned PI_STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_am_req,
  input  logic [ADDR_W-1:0] i_am_addr,
  input  logic              i_am_we,
  input  logic [1:0]        i_am_be_n,
  input  logic [DATA_W-1:0] i_am_wdata,
  output logic [DATA_W-1:0] o_am_rdata,
  output logic              o_am_done,
  input  logic              i_pi_req,
  input  logic [ADDR_W-1:0] i_pi_addr,
  input  logic              i_pi_we,
  input  logic [1:0]        i_pi_be_n,
  input  logic [DATA_W-1:0] i_pi_wdata,
  output logic [DATA_W-1:0] o_pi_rdata,
  output logic              o_pi_done,
  output logic [ADDR_W-1:0] o_sram_a,
  output logic [DATA_W-1:0] o_sram_d_out,
  output logic              o_sram_d_oe,
  input  logic [DATA_W-1:0] i_sram_d_in,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n,
  output logic              o_busy
);

  localparam int unsigned CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned STARVE_W = $clog2(PI_STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_SAMPLE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_sel_pi;
  logic                r_we;

  logic                w_am_elig;
  logic                w_pi_elig;
  logic                w_grant_am;
  logic                w_grant_pi;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [1:0]          w_be_n;
  logic                w_we;

  // A requester whose done is still high has already been served for this request.
  assign w_am_elig  = i_am_req && !o_am_done;
  assign w_pi_elig  = i_pi_req && !o_pi_done;
  assign w_grant_am = w_am_elig && (!w_pi_elig || (r_starve_cnt < STARVE_W'(PI_STARVE_LIMIT)));
  assign w_grant_pi = !w_grant_am && w_pi_elig;

  assign w_addr  = w_grant_pi ? i_pi_addr  : i_am_addr;
  assign w_wdata = w_grant_pi ? i_pi_wdata : i_am_wdata;
  assign w_be_n  = w_grant_pi ? i_pi_be_n  : i_am_be_n;
  assign w_we    = w_grant_pi ? i_pi_we    : i_am_we;

  // Access sequencer: setup on grant, strobe, sample, one recovery cycle for bus turnaround.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_sel_pi     <= 1'b0;
      r_we         <= 1'b0;
      o_am_rdata   <= '0;
      o_am_done    <= 1'b0;
      o_pi_rdata   <= '0;
      o_pi_done    <= 1'b0;
      o_sram_a     <= '0;
      o_sram_d_out <= '0;
      o_sram_d_oe  <= 1'b0;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      if (!i_am_req) o_am_done <= 1'b0;
      if (!i_pi_req) o_pi_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant_am || w_grant_pi) begin
            r_sel_pi     <= w_grant_pi;
            r_we         <= w_we;
            o_sram_a     <= w_addr;
            o_sram_d_out <= w_wdata;
            o_sram_ub_n  <= w_be_n[1];
            o_sram_lb_n  <= w_be_n[0];
            o_sram_oe_n  <= w_we;
            o_sram_we_n  <= !w_we;
            o_sram_d_oe  <= w_we;
            r_wait_cnt   <= CNT_W'(WAIT_CYCLES);
            o_busy       <= 1'b1;
            r_state      <= S_STROBE;
            if (w_grant_am && w_pi_elig) begin
              if (r_starve_cnt != STARVE_W'(PI_STARVE_LIMIT))
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end

        S_STROBE: begin
          if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          else                  r_state    <= S_SAMPLE;
        end

        S_SAMPLE: begin
          if (!r_we) begin
            if (r_sel_pi) o_pi_rdata <= i_sram_d_in;
            else          o_am_rdata <= i_sram_d_in;
          end
          if (r_sel_pi) o_pi_done <= 1'b1;
          else          o_am_done <= 1'b1;
          o_sram_we_n <= 1'b1;
          o_sram_oe_n <= 1'b1;
          o_sram_ub_n <= 1'b1;
          o_sram_lb_n <= 1'b1;
          r_state     <= S_RECOVER;
        end

        S_RECOVER: begin
          o_sram_d_oe <= 1'b0;
          o_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
